fetch_unit: RTL

- Program-counter and IF/ID pipeline-register stage of the single-issue RISC-V datapath.
- Sits directly upstream of the combinational instruction memory: drives `memAddress` and consumes the returned `instruction`.
- Registers the fetched word, its PC and PC+4 for the decode stage.
- Handles stall, branch/jump redirect with flush, and end-of-program halt.

---
 rtl/datapath_pkg.sv | 16 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-issue RISC-V datapath.
//   XLEN          : datapath / address width
//   NOP_WORD      : addi x0,x0,0, used as the pipeline bubble
//   fetch_state_t : fetch-stage sequencing (BOOT, RUN, HALT)
package datapath_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset  : rising-edge clock, async active-high reset (loads the bubble)
//   load        : capture instrIn/pcIn/pcPlus4In as a valid instruction
//   flush       : load the bubble (NOP_WORD, pc 0, valid 0); wins over load
//   (neither)   : hold
//   *Out        : registered contents presented to decode
module if_id_reg #(
  parameter int unsigned XLEN     = datapath_pkg::XLEN,
  parameter logic [31:0] NOP_WORD = datapath_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     instrIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic [XLEN-1:0] pcPlus4In,
  output logic [31:0]     instrOut,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlus4Out,
  output logic            validOut
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrOut   <= NOP_WORD;
      pcOut      <= '0;
      pcPlus4Out <= '0;
      validOut   <= 1'b0;
    end else if (flush) begin
      instrOut   <= NOP_WORD;
      pcOut      <= '0;
      pcPlus4Out <= '0;
      validOut   <= 1'b0;
    end else if (load) begin
      instrOut   <= instrIn;
      pcOut      <= pcIn;
      pcPlus4Out <= pcPlus4In;
      validOut   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter + IF/ID stage of the single-issue RISC-V datapath.
// Drives the combinational instruction memory with the current PC and
// registers the returned word, its PC and PC+4 for decode.
//   clk, reset        : rising-edge clock, async active-high reset
//   stall             : hold PC and IF/ID (RUN only)
//   branchTaken/Target: redirect from EX; flushes IF/ID, beats stall
//   memAddress        : current PC to instruction memory
//   instruction       : word returned by instruction memory
//   ifId*             : IF/ID register contents
//   halted            : PC ran past the program; bubbles until redirected
//   misaligned        : sticky, a redirect target had nonzero low bits
//   fetchCount        : only with FETCH_PERF_COUNT_EN; valid IF/ID loads
// Optional feature macro: FETCH_PERF_COUNT_EN
module fetch_unit
  import datapath_pkg::*;
#(
  parameter int unsigned     XLEN             = datapath_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC         = '0,
  parameter int unsigned     NUM_INSTRUCTIONS = 3,
  parameter logic [31:0]     NOP_WORD         = datapath_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  output logic [XLEN-1:0] memAddress,
  input  logic [31:0]     instruction,
  output logic [31:0]     ifIdInstruction,
  output logic [XLEN-1:0] ifIdPc,
  output logic [XLEN-1:0] ifIdPcPlus4,
  output logic            ifIdValid,
  output logic            halted,
  output logic            misaligned
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]     fetchCount
`endif
);

  // End of program computed wide so RESET_PC + 4*NUM_INSTRUCTIONS cannot
  // wrap; the compare against the zero-extended PC stays plain unsigned.
  localparam logic [63:0] PROG_END = 64'(RESET_PC) + (64'(NUM_INSTRUCTIONS) << 2);

  fetch_state_t    state, stateNext;
  logic [XLEN-1:0] pc, pcNext, pcPlus4, tgtAligned;
  logic            misNext, load, flush, beyond;

  assign pcPlus4    = pc + XLEN'(4);
  assign tgtAligned = {branchTarget[XLEN-1:2], 2'b00};
  assign beyond     = (64'(pc) >= PROG_END);
  assign memAddress = pc;
  assign halted     = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      misaligned <= misNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    misNext   = misaligned;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        if (branchTaken) begin
          pcNext  = tgtAligned;
          flush   = 1'b1;
          misNext = misaligned | (branchTarget[1:0] != 2'b00);
        end else if (stall) begin
          // hold everything
        end else if (beyond) begin
          flush     = 1'b1;
          stateNext = HALT;
        end else begin
          load   = 1'b1;
          pcNext = pcPlus4;
        end
      end
      HALT: begin
        flush = 1'b1;
        if (branchTaken) begin
          pcNext    = tgtAligned;
          misNext   = misaligned | (branchTarget[1:0] != 2'b00);
          stateNext = RUN;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  if_id_reg #(
    .XLEN     (XLEN),
    .NOP_WORD (NOP_WORD)
  ) u_ifId (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (flush),
    .instrIn    (instruction),
    .pcIn       (pc),
    .pcPlus4In  (pcPlus4),
    .instrOut   (ifIdInstruction),
    .pcOut      (ifIdPc),
    .pcPlus4Out (ifIdPcPlus4),
    .validOut   (ifIdValid)
  );

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     fetchCount <= '0;
    else if (load) fetchCount <= fetchCount + 32'd1;
  end
`endif

endmodule
